// File: rtl/probe_capture.sv
// Probe capture FIFO with per-sample cycle timestamps and a run/finish/timeout watchdog.
// Define PROBE_CAPTURE_TIMESTAMP_EN to store cyc with each sample; otherwise rd_ts reads 0.
module probe_capture #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int TS_W       = 16,
  parameter int MAX_CYCLES = 11
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cap_en,
  input  logic [DATA_W-1:0]        probe,
  input  logic                     done,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TS_W-1:0]          rd_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     finished,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TS_W-1:0] CYC_SAT    = '1;
  localparam logic [TS_W-1:0] CYC_LIMIT  = TS_W'(MAX_CYCLES);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FINISHED,
    ST_TIMEOUT
  } state_t;

  logic [TS_W-1:0]   cyc_reg;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              overflow_reg;
  state_t            state_reg;
  logic              finished_reg;
  logic              timeout_reg;

  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  logic [DATA_W-1:0] data_mem [DEPTH];

  always_comb begin
    full = (count_reg == FULL_COUNT);
    pop  = (count_reg != '0) && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push = cap_en && (!full || pop);
    drop = cap_en && full && !pop;
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (cyc_reg != CYC_SAT)
        cyc_reg <= cyc_reg + 1'b1;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  // Storage is never cleared; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push && !reset)
      data_mem[wr_ptr_reg] <= probe;
  end

`ifdef PROBE_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (push && !reset)
      ts_mem[wr_ptr_reg] <= cyc_reg;
  end

  assign rd_ts = rd_valid ? ts_mem[rd_ptr_reg] : '0;
`else
  assign rd_ts = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      finished_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          // done in the limit cycle itself still counts as a finish
          if (done && (cyc_reg <= CYC_LIMIT)) begin
            state_reg    <= ST_FINISHED;
            finished_reg <= 1'b1;
          end else if (cyc_reg == CYC_LIMIT) begin
            state_reg   <= ST_TIMEOUT;
            timeout_reg <= 1'b1;
          end
        end
        ST_FINISHED: begin
          state_reg    <= ST_FINISHED;
          finished_reg <= 1'b1;
          timeout_reg  <= 1'b0;
        end
        ST_TIMEOUT: begin
          state_reg    <= ST_TIMEOUT;
          finished_reg <= 1'b0;
          timeout_reg  <= 1'b1;
        end
        default: begin
          state_reg    <= ST_RUN;
          finished_reg <= 1'b0;
          timeout_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_valid = (count_reg != '0);
  assign rd_data  = rd_valid ? data_mem[rd_ptr_reg] : '0;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign finished = finished_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_probe_capture.sv
// Self-checking bench for probe_capture: directed scenarios plus a random run against a queue model.
module tb_probe_capture;

  localparam int DEPTH = 16;
  localparam int MAXC  = 11;

  logic        clock = 1'b0;
  logic        reset;
  logic        cap_en;
  logic [7:0]  probe;
  logic        done;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic [15:0] rd_ts;
  logic [4:0]  count;
  logic        overflow;
  logic        finished;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sample queue, sticky flags, free-running cycle number.
  logic [7:0] q_data[$];
  int         q_ts[$];
  bit         m_ovf, m_fin, m_to;
  int         m_cyc;

  probe_capture #(.DATA_W(8), .DEPTH(DEPTH), .TS_W(16), .MAX_CYCLES(MAXC)) dut (
    .clock(clock), .reset(reset), .cap_en(cap_en), .probe(probe), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_ts(rd_ts),
    .count(count), .overflow(overflow), .finished(finished), .timeout(timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] exp_data();
    return (q_data.size() > 0) ? q_data[0] : 8'h00;
  endfunction

  function automatic logic [15:0] exp_ts();
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    return (q_ts.size() > 0) ? 16'(q_ts[0]) : 16'h0000;
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] ts_of(input int c);
`ifdef PROBE_CAPTURE_TIMESTAMP_EN
    return 16'(c);
`else
    return 16'h0000;
`endif
  endfunction

  // Apply one cycle of inputs, clock it, advance the model, sample at edge+1.
  task automatic cycle(input bit rst, input bit cap, input logic [7:0] p, input bit rdy, input bit dn);
    reset = rst; cap_en = cap; probe = p; rd_ready = rdy; done = dn;
    @(posedge clock);
    if (rst) begin
      q_data.delete(); q_ts.delete();
      m_ovf = 0; m_fin = 0; m_to = 0; m_cyc = 0;
    end else begin
      bit pop, full;
      pop  = (q_data.size() > 0) && rdy;
      full = (q_data.size() == DEPTH);
      if (cap && full && !pop) m_ovf = 1;
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_ts.pop_front());
      end
      if (cap && (!full || pop)) begin
        q_data.push_back(p);
        q_ts.push_back(m_cyc);
      end
      if (!m_fin && !m_to) begin
        if (dn) m_fin = 1;
        else if (m_cyc == MAXC) m_to = 1;
      end
      if (m_cyc < 65535) m_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, 8'h5A, 1, 1);
    cycle(1, 0, 8'h00, 0, 0);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (finished !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL reset_fsm: got fin=%b to=%b expected 0 0", finished, timeout); end
    n_checks++; if (rd_data !== 8'h00 || rd_ts !== 16'h0000) begin n_fail++; $display("FAIL reset_head: got %h/%h expected 00/0000", rd_data, rd_ts); end
    $display("test_reset done");
  endtask

  task automatic test_first_sample();
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 8'($urandom), 1, 0);
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL first_pre_valid: got %b expected 0", rd_valid); end
    cycle(0, 1, 8'hA5, 1, 0);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", rd_valid); end
    n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL first_data: got %h expected a5", rd_data); end
    n_checks++; if (rd_ts !== ts_of(3)) begin n_fail++; $display("FAIL first_ts: got %0d expected %0d", rd_ts, ts_of(3)); end
    cycle(0, 0, 8'h00, 1, 0);
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL first_popped: got v=%b d=%h expected 0 00", rd_valid, rd_data); end
    $display("test_first_sample done");
  endtask

  task automatic test_overflow();
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(i * 7 + 3), 0, 0);
    n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill: got cnt=%0d ovf=%b expected 16 0", count, overflow); end
    cycle(0, 1, 8'hFF, 0, 0);
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_checks++; if (rd_data !== 8'h03 || rd_ts !== ts_of(0)) begin n_fail++; $display("FAIL ovf_head: got %h/%0d expected 03/%0d", rd_data, rd_ts, ts_of(0)); end
    $display("test_overflow done");
  endtask

  task automatic test_full_push_pop();
    logic [7:0] want;
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 8'(8'h40 + i), 0, 0);
    cycle(0, 1, 8'hC3, 1, 0);
    n_checks++; if (count !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_count: got cnt=%0d ovf=%b expected 16 0", count, overflow); end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 8'($urandom), 0, 0);
      n_checks++; if (rd_data !== 8'h41 || rd_ts !== ts_of(1)) begin n_fail++; $display("FAIL fpp_hold: got %h/%0d expected 41/%0d", rd_data, rd_ts, ts_of(1)); end
    end
    for (int i = 0; i < 16; i++) begin
      want = (i < 15) ? 8'(8'h41 + i) : 8'hC3;
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== want) begin n_fail++; $display("FAIL fpp_drain%0d: got v=%b d=%h expected 1 %h", i, rd_valid, rd_data, want); end
      cycle(0, 0, 8'h00, 1, 0);
    end
    n_checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin n_fail++; $display("FAIL fpp_empty: got v=%b cnt=%0d expected 0 0", rd_valid, count); end
    $display("test_full_push_pop done");
  endtask

  task automatic test_done_early();
    cycle(1, 0, 8'h00, 0, 0);
    for (int c = 0; c <= 20; c++) begin
      n_checks++; if (finished !== (c > 7) || timeout !== 1'b0) begin n_fail++; $display("FAIL done7_c%0d: got fin=%b to=%b expected %b 0", c, finished, timeout, c > 7); end
      cycle(0, 0, 8'h00, 0, (c == 7) || (c == 15));
    end
    cycle(1, 0, 8'h00, 0, 0);
    for (int c = 0; c <= 13; c++) begin
      n_checks++; if (finished !== (c > 11) || timeout !== 1'b0) begin n_fail++; $display("FAIL done11_c%0d: got fin=%b to=%b expected %b 0", c, finished, timeout, c > 11); end
      cycle(0, 0, 8'h00, 0, c == 11);
    end
    $display("test_done_early done");
  endtask

  task automatic test_timeout_reset();
    cycle(1, 0, 8'h00, 0, 0);
    for (int c = 0; c <= 15; c++) begin
      n_checks++; if (timeout !== (c > 11) || finished !== 1'b0) begin n_fail++; $display("FAIL to_c%0d: got to=%b fin=%b expected %b 0", c, timeout, finished, c > 11); end
      cycle(0, c < 5, 8'(c + 8'h10), 0, (c == 13));
    end
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL to_count5: got %0d expected 5", count); end
    cycle(1, 1, 8'h99, 1, 0);
    n_checks++; if (count !== 5'd0 || rd_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_reset: got cnt=%0d v=%b to=%b expected 0 0 0", count, rd_valid, timeout); end
    cycle(0, 0, 8'h00, 0, 0);
    n_checks++; if (count !== 5'd0 || rd_data !== 8'h00) begin n_fail++; $display("FAIL to_discard: got cnt=%0d d=%h expected 0 00", count, rd_data); end
    $display("test_timeout_reset done");
  endtask

  task automatic test_random();
    logic [37:0] got, want;
    cycle(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 800; i++) begin
      got  = {rd_valid, count, overflow, finished, timeout, rd_data, rd_ts};
      want = {q_data.size() > 0, 5'(q_data.size()), m_ovf, m_fin, m_to, exp_data(), exp_ts()};
      n_checks++; if (got !== want) begin n_fail++; $display("FAIL random_%0d: got %h expected %h", i, got, want); end
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 6, 8'($urandom),
            $urandom_range(0, 9) < 4, $urandom_range(0, 24) == 0);
    end
    $display("test_random done");
  endtask

  initial begin
    reset = 1'b1; cap_en = 1'b0; probe = 8'h00; rd_ready = 1'b0; done = 1'b0;
    test_reset();
    test_first_sample();
    test_overflow();
    test_full_push_pop();
    test_done_early();
    test_timeout_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
